dec_exec_mem_slice: RTL and testbench
=====================================

# dec_exec_mem_slice

Middle slice of the 5-stage MIPS pipeline: the decode stage (register file, immediate extension, branch target, early branch compare), the execute stage (forwarding muxes, destination select, ALU) and the EX/MEM pipeline register. It sits between the IF/ID register and the MEM/WB register. The ID/EX register, hazard unit and controller are external. The block's own EX/MEM outputs feed back internally as the MEM forwarding source.

## Interface
Parameters: none (32-bit datapath, 32×32 register file, fixed).

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high
- instr_id32, pc_plus4_id32  in  32 each  decode instruction and PC+4 from IF/ID
- branch_i  in  1  decode instruction is a branch
- forward_rd1_id, forward_rd2_id  in  1 each  use MEM ALU result for branch compare operand A/B
- dst_reg_addr_iwb5  in  5; res_iwb32  in  32; enable_wreg_iwb  in  1  writeback port
- op_o6, funct_o6  out  6 each  instr[31:26], instr[5:0]
- rd1_o32, rd2_o32  out  32 each  register reads of rs, rt
- sign_imm_o32, se_shamt_o32, pc_branch_o32  out  32 each  decode results
- id_eq_o, branch_o  out  1 each  branch compare equal; branch taken
- rd1_ie32, rd2_ie32, sign_imm_ie32, se_shamt_ie32  in  32 each  EX operands from ID/EX
- rt_ie5, rd_ie5  in  5 each; funct_ie6  in  6
- forward_src_a_ie2, forward_src_b_ie2, alu_alt_ctrl_ie2  in  2 each
- reg_dst_rtrd_ie, b_alu_input_ie, apply_shift_ie  in  1 each
- enable_wreg_ie, mem_to_reg_ie, enable_wmem_ie  in  1 each  controls carried to MEM
- ex_write_data_o32, ex_alu_out_o32  out  32 each; ex_dst_reg_addr_o5  out  5; ex_zero_o  out  1  combinational EX results
- alu_out_om32, write_data_om32  out  32 each; dst_reg_addr_om5  out  5; enable_wreg_om, mem_to_reg_om, enable_wmem_om  out  1 each  EX/MEM register

## Operation
Decode:
- Register file: 32×32; r0 reads 0 and ignores writes. Read is combinational.
- Writes occur on a rising edge when enable_wreg_iwb=1 and dst_reg_addr_iwb5≠0.
- Write-through: if a read address equals dst_reg_addr_iwb5 (≠0) with enable_wreg_iwb=1, the read returns res_iwb32 in the same cycle.
- sign_imm = sign-extend instr[15:0]. se_shamt = zero-extend instr[10:6].
- pc_branch = pc_plus4 + (sign_imm << 2), modulo 2^32.
- Compare operand A = forward_rd1_id ? alu_out_om32 : rd1. Operand B uses forward_rd2_id and rd2 the same way.
- id_eq_o = (A==B). branch_o = branch_i & id_eq_o.
- rd1_o32/rd2_o32 are the unforwarded register-file values.

Execute:
- Forward select for srcA (from rd1_ie32) and write_data (from rd2_ie32): 00 → ID/EX value, 01 → res_iwb32, 10 → alu_out_om32, 11 → ID/EX value.
- ALU A = apply_shift_ie ? se_shamt_ie32 : srcA.
- ALU B = b_alu_input_ie ? sign_imm_ie32 : write_data.
- alu_alt_ctrl: 00 add, 01 sub, 11 signed slt, 10 decode funct.
- funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed slt, 000000 sll (B << A[4:0]), 000010 srl (B >> A[4:0], logical). Any other funct performs add.
- Add and sub wrap modulo 2^32, no overflow trap. slt result is 1 or 0.
- ex_zero_o = (ALU result == 0).
- ex_dst_reg_addr = reg_dst_rtrd_ie ? rd_ie5 : rt_ie5.

EX/MEM register: captures ALU result, write_data, dst address and the three controls every cycle. No stall or flush input.

## Timing
- Decode and execute outputs are purely combinational, with zero latency.
- The EX/MEM register has 1-cycle latency.
- Register-file write is visible to reads at the same edge's following cycle. Same-cycle reads see it via write-through.
- Synchronous reset clears all EX/MEM outputs and all 32 registers to 0. Reset overrides a simultaneous writeback.
- During reset, combinational outputs still follow their inputs, using zeroed state after the edge.

## Test plan
- Regfile: write r5=0x1234 (enable_wreg_iwb=1); same cycle, instr rs=5 → rd1_o32=0x1234. Next cycle it is still 0x1234. A write to r0 leaves rd=0.
- Immediate/branch: instr[15:0]=0xFFFC, pc_plus4=0x100 → sign_imm=0xFFFFFFFC, pc_branch=0xF0. instr[10:6]=7 → se_shamt=7.
- Branch compare: rd1≠rd2 but forward_rd1_id=1 with alu_out_om32 equal to rd2, branch_i=1 → id_eq_o=1, branch_o=1. With branch_i=0 → branch_o=0.
- ALU: alt=10 funct sub, 5−7 → 0xFFFFFFFE, ex_zero_o=0. alt=11, -1 slt 1 → 1. apply_shift=1, se_shamt=4, funct sll, rt=1 → 0x10.
- Forwarding: forward_src_b=01, res_iwb=0xAA → ex_write_data=0xAA. forward_src_a=10 uses alu_out_om32. reg_dst_rtrd=1 picks rd_ie5.
- Pipeline register: EX result 0x55 with enable_wmem_ie=1 appears on alu_out_om32/enable_wmem_om after one edge. reset_i high for one edge → all EX/MEM outputs 0.

Source files
------------

// File: rtl/dec_exec_mem_slice_if.sv
// Bus bundle for the decode/execute/EX-MEM pipeline slice.
// The slave modport is the slice's own view of the bus.
interface dec_exec_mem_slice_if;
    logic [31:0] instr_id32;
    logic [31:0] pc_plus4_id32;
    logic        branch_i;
    logic        forward_rd1_id;
    logic        forward_rd2_id;
    logic [4:0]  dst_reg_addr_iwb5;
    logic [31:0] res_iwb32;
    logic        enable_wreg_iwb;
    logic [5:0]  op_o6;
    logic [5:0]  funct_o6;
    logic [31:0] rd1_o32;
    logic [31:0] rd2_o32;
    logic [31:0] sign_imm_o32;
    logic [31:0] se_shamt_o32;
    logic [31:0] pc_branch_o32;
    logic        id_eq_o;
    logic        branch_o;
    logic [31:0] rd1_ie32;
    logic [31:0] rd2_ie32;
    logic [31:0] sign_imm_ie32;
    logic [31:0] se_shamt_ie32;
    logic [4:0]  rt_ie5;
    logic [4:0]  rd_ie5;
    logic [5:0]  funct_ie6;
    logic [1:0]  forward_src_a_ie2;
    logic [1:0]  forward_src_b_ie2;
    logic [1:0]  alu_alt_ctrl_ie2;
    logic        reg_dst_rtrd_ie;
    logic        b_alu_input_ie;
    logic        apply_shift_ie;
    logic        enable_wreg_ie;
    logic        mem_to_reg_ie;
    logic        enable_wmem_ie;
    logic [31:0] ex_write_data_o32;
    logic [31:0] ex_alu_out_o32;
    logic [4:0]  ex_dst_reg_addr_o5;
    logic        ex_zero_o;
    logic [31:0] alu_out_om32;
    logic [31:0] write_data_om32;
    logic [4:0]  dst_reg_addr_om5;
    logic        enable_wreg_om;
    logic        mem_to_reg_om;
    logic        enable_wmem_om;

    modport slave (
        input  instr_id32, pc_plus4_id32, branch_i,
        input  forward_rd1_id, forward_rd2_id,
        input  dst_reg_addr_iwb5, res_iwb32, enable_wreg_iwb,
        output op_o6, funct_o6, rd1_o32, rd2_o32,
        output sign_imm_o32, se_shamt_o32, pc_branch_o32,
        output id_eq_o, branch_o,
        input  rd1_ie32, rd2_ie32, sign_imm_ie32, se_shamt_ie32,
        input  rt_ie5, rd_ie5, funct_ie6,
        input  forward_src_a_ie2, forward_src_b_ie2, alu_alt_ctrl_ie2,
        input  reg_dst_rtrd_ie, b_alu_input_ie, apply_shift_ie,
        input  enable_wreg_ie, mem_to_reg_ie, enable_wmem_ie,
        output ex_write_data_o32, ex_alu_out_o32,
        output ex_dst_reg_addr_o5, ex_zero_o,
        output alu_out_om32, write_data_om32, dst_reg_addr_om5,
        output enable_wreg_om, mem_to_reg_om, enable_wmem_om
    );

    modport master (
        output instr_id32, pc_plus4_id32, branch_i,
        output forward_rd1_id, forward_rd2_id,
        output dst_reg_addr_iwb5, res_iwb32, enable_wreg_iwb,
        input  op_o6, funct_o6, rd1_o32, rd2_o32,
        input  sign_imm_o32, se_shamt_o32, pc_branch_o32,
        input  id_eq_o, branch_o,
        output rd1_ie32, rd2_ie32, sign_imm_ie32, se_shamt_ie32,
        output rt_ie5, rd_ie5, funct_ie6,
        output forward_src_a_ie2, forward_src_b_ie2, alu_alt_ctrl_ie2,
        output reg_dst_rtrd_ie, b_alu_input_ie, apply_shift_ie,
        output enable_wreg_ie, mem_to_reg_ie, enable_wmem_ie,
        input  ex_write_data_o32, ex_alu_out_o32,
        input  ex_dst_reg_addr_o5, ex_zero_o,
        input  alu_out_om32, write_data_om32, dst_reg_addr_om5,
        input  enable_wreg_om, mem_to_reg_om, enable_wmem_om
    );
endinterface

// File: rtl/dec_exec_mem_slice.sv
// MIPS decode + execute stages with the EX/MEM pipeline register.
// The EX/MEM ALU result loops back as the MEM forwarding source.
module dec_exec_mem_slice (
    input logic                  clk_i,
    input logic                  reset_i,
    dec_exec_mem_slice_if.slave  bus
);
    logic [31:0] rf_q [32];
    logic [4:0]  rs, rt;
    logic [31:0] rd1, rd2, sign_imm;
    logic [31:0] cmp_a, cmp_b;
    logic [31:0] src_a, wr_data, alu_a, alu_b, alu_res;
    logic [4:0]  dst;

    logic [31:0] alu_q, alu_d;
    logic [31:0] wd_q, wd_d;
    logic [4:0]  dst_q, dst_d;
    logic        wreg_q, wreg_d;
    logic        m2r_q, m2r_d;
    logic        wmem_q, wmem_d;

    assign rs = bus.instr_id32[25:21];
    assign rt = bus.instr_id32[20:16];

    // Writeback data bypasses the array so same-cycle reads see it.
    always_comb begin
        rd1 = rf_q[rs];
        rd2 = rf_q[rt];
        if (bus.enable_wreg_iwb && bus.dst_reg_addr_iwb5 == rs)
            rd1 = bus.res_iwb32;
        if (bus.enable_wreg_iwb && bus.dst_reg_addr_iwb5 == rt)
            rd2 = bus.res_iwb32;
        if (rs == 5'd0)
            rd1 = 32'd0;
        if (rt == 5'd0)
            rd2 = 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
        end else if (bus.enable_wreg_iwb &&
                     bus.dst_reg_addr_iwb5 != 5'd0) begin
            rf_q[bus.dst_reg_addr_iwb5] <= bus.res_iwb32;
        end
    end

    assign sign_imm = {{16{bus.instr_id32[15]}},
                       bus.instr_id32[15:0]};
    assign cmp_a = bus.forward_rd1_id ? alu_q : rd1;
    assign cmp_b = bus.forward_rd2_id ? alu_q : rd2;

    assign bus.op_o6         = bus.instr_id32[31:26];
    assign bus.funct_o6      = bus.instr_id32[5:0];
    assign bus.rd1_o32       = rd1;
    assign bus.rd2_o32       = rd2;
    assign bus.sign_imm_o32  = sign_imm;
    assign bus.se_shamt_o32  = {27'd0, bus.instr_id32[10:6]};
    assign bus.pc_branch_o32 = bus.pc_plus4_id32 +
                               {sign_imm[29:0], 2'b00};
    assign bus.id_eq_o       = (cmp_a == cmp_b);
    assign bus.branch_o      = bus.branch_i & (cmp_a == cmp_b);

    always_comb begin
        unique case (bus.forward_src_a_ie2)
            2'b01:   src_a = bus.res_iwb32;
            2'b10:   src_a = alu_q;
            default: src_a = bus.rd1_ie32;
        endcase
        unique case (bus.forward_src_b_ie2)
            2'b01:   wr_data = bus.res_iwb32;
            2'b10:   wr_data = alu_q;
            default: wr_data = bus.rd2_ie32;
        endcase
    end

    assign alu_a = bus.apply_shift_ie ? bus.se_shamt_ie32 : src_a;
    assign alu_b = bus.b_alu_input_ie ? bus.sign_imm_ie32 : wr_data;

    always_comb begin
        alu_res = alu_a + alu_b;
        unique case (bus.alu_alt_ctrl_ie2)
            2'b01: alu_res = alu_a - alu_b;
            2'b11: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            2'b10: begin
                unique case (bus.funct_ie6)
                    6'b100010: alu_res = alu_a - alu_b;
                    6'b100100: alu_res = alu_a & alu_b;
                    6'b100101: alu_res = alu_a | alu_b;
                    6'b101010:
                        alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
                    6'b000000: alu_res = alu_b << alu_a[4:0];
                    6'b000010: alu_res = alu_b >> alu_a[4:0];
                    default:   alu_res = alu_a + alu_b;
                endcase
            end
            default: alu_res = alu_a + alu_b;
        endcase
    end

    assign dst = bus.reg_dst_rtrd_ie ? bus.rd_ie5 : bus.rt_ie5;

    assign bus.ex_write_data_o32  = wr_data;
    assign bus.ex_alu_out_o32     = alu_res;
    assign bus.ex_dst_reg_addr_o5 = dst;
    assign bus.ex_zero_o          = (alu_res == 32'd0);

    always_comb begin
        alu_d  = alu_res;
        wd_d   = wr_data;
        dst_d  = dst;
        wreg_d = bus.enable_wreg_ie;
        m2r_d  = bus.mem_to_reg_ie;
        wmem_d = bus.enable_wmem_ie;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alu_q  <= 32'd0;
            wd_q   <= 32'd0;
            dst_q  <= 5'd0;
            wreg_q <= 1'b0;
            m2r_q  <= 1'b0;
            wmem_q <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            wd_q   <= wd_d;
            dst_q  <= dst_d;
            wreg_q <= wreg_d;
            m2r_q  <= m2r_d;
            wmem_q <= wmem_d;
        end
    end

    assign bus.alu_out_om32     = alu_q;
    assign bus.write_data_om32  = wd_q;
    assign bus.dst_reg_addr_om5 = dst_q;
    assign bus.enable_wreg_om   = wreg_q;
    assign bus.mem_to_reg_om    = m2r_q;
    assign bus.enable_wmem_om   = wmem_q;
endmodule

// File: tb/tb_dec_exec_mem_slice.sv
// Directed + random bench for dec_exec_mem_slice against an
// architectural model (register array, MIPS ALU semantics).
module tb_dec_exec_mem_slice;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dec_exec_mem_slice_if bus();
    dec_exec_mem_slice dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];
    logic [31:0] m_alu, m_wd;
    logic [4:0]  m_dst;
    logic        m_wreg, m_m2r, m_wmem;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(logic [4:0] a);
        if (a == 0) return 32'd0;
        if (bus.enable_wreg_iwb && bus.dst_reg_addr_iwb5 == a)
            return bus.res_iwb32;
        return regs[a];
    endfunction

    function automatic logic [31:0] fsel(logic [1:0] s, logic [31:0] v);
        if (s == 2'd1) return bus.res_iwb32;
        if (s == 2'd2) return m_alu;
        return v;
    endfunction

    function automatic logic [31:0] alu(logic [1:0] alt, logic [5:0] f,
                                        logic [31:0] a, logic [31:0] b);
        logic lt;
        lt = $signed(a) < $signed(b);
        if (alt == 2'd1) return a - b;
        if (alt == 2'd3) return lt ? 32'd1 : 32'd0;
        if (alt == 2'd0) return a + b;
        case (f)
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2a:   return lt ? 32'd1 : 32'd0;
            6'h00:   return b << a[4:0];
            6'h02:   return b >> a[4:0];
            default: return a + b;
        endcase
    endfunction

    task automatic check_om();
        chk("om_alu", bus.alu_out_om32, m_alu);
        chk("om_wd", bus.write_data_om32, m_wd);
        chk("om_dst", {27'd0, bus.dst_reg_addr_om5}, {27'd0, m_dst});
        chk("om_ctl", {29'd0, bus.enable_wreg_om, bus.mem_to_reg_om,
                       bus.enable_wmem_om},
            {29'd0, m_wreg, m_m2r, m_wmem});
    endtask

    task automatic step();
        logic [31:0] r1, r2, si, a, b, sa, wd, aa, ab, res;
        logic [4:0]  dst;
        logic        eq;
        #1;
        r1 = rd(bus.instr_id32[25:21]);
        r2 = rd(bus.instr_id32[20:16]);
        si = 32'($signed(bus.instr_id32[15:0]));
        a  = bus.forward_rd1_id ? m_alu : r1;
        b  = bus.forward_rd2_id ? m_alu : r2;
        eq = (a == b);
        chk("op", {26'd0, bus.op_o6}, {26'd0, bus.instr_id32[31:26]});
        chk("funct", {26'd0, bus.funct_o6}, {26'd0, bus.instr_id32[5:0]});
        chk("rd1", bus.rd1_o32, r1);
        chk("rd2", bus.rd2_o32, r2);
        chk("sign_imm", bus.sign_imm_o32, si);
        chk("shamt", bus.se_shamt_o32, 32'(bus.instr_id32[10:6]));
        chk("pc_branch", bus.pc_branch_o32, bus.pc_plus4_id32 + si * 4);
        chk("id_eq", {31'd0, bus.id_eq_o}, {31'd0, eq});
        chk("branch", {31'd0, bus.branch_o}, {31'd0, eq & bus.branch_i});
        sa  = fsel(bus.forward_src_a_ie2, bus.rd1_ie32);
        wd  = fsel(bus.forward_src_b_ie2, bus.rd2_ie32);
        aa  = bus.apply_shift_ie ? bus.se_shamt_ie32 : sa;
        ab  = bus.b_alu_input_ie ? bus.sign_imm_ie32 : wd;
        res = alu(bus.alu_alt_ctrl_ie2, bus.funct_ie6, aa, ab);
        dst = bus.reg_dst_rtrd_ie ? bus.rd_ie5 : bus.rt_ie5;
        chk("ex_wd", bus.ex_write_data_o32, wd);
        chk("ex_alu", bus.ex_alu_out_o32, res);
        chk("ex_dst", {27'd0, bus.ex_dst_reg_addr_o5}, {27'd0, dst});
        chk("ex_zero", {31'd0, bus.ex_zero_o}, {31'd0, res == 0});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] = 32'd0;
            {m_alu, m_wd, m_dst, m_wreg, m_m2r, m_wmem} = '0;
        end else begin
            if (bus.enable_wreg_iwb && bus.dst_reg_addr_iwb5 != 0)
                regs[bus.dst_reg_addr_iwb5] = bus.res_iwb32;
            m_alu  = res;
            m_wd   = wd;
            m_dst  = dst;
            m_wreg = bus.enable_wreg_ie;
            m_m2r  = bus.mem_to_reg_ie;
            m_wmem = bus.enable_wmem_ie;
        end
        #1;
        check_om();
    endtask

    function automatic logic [31:0] mk(logic [4:0] s, logic [4:0] t,
                                       logic [15:0] imm);
        return {6'd0, s, t, imm};
    endfunction

    initial begin
        bus.instr_id32 = 0;        bus.pc_plus4_id32 = 0;
        bus.branch_i = 0;          bus.forward_rd1_id = 0;
        bus.forward_rd2_id = 0;    bus.dst_reg_addr_iwb5 = 0;
        bus.res_iwb32 = 0;         bus.enable_wreg_iwb = 0;
        bus.rd1_ie32 = 0;          bus.rd2_ie32 = 0;
        bus.sign_imm_ie32 = 0;     bus.se_shamt_ie32 = 0;
        bus.rt_ie5 = 0;            bus.rd_ie5 = 0;
        bus.funct_ie6 = 0;         bus.forward_src_a_ie2 = 0;
        bus.forward_src_b_ie2 = 0; bus.alu_alt_ctrl_ie2 = 0;
        bus.reg_dst_rtrd_ie = 0;   bus.b_alu_input_ie = 0;
        bus.apply_shift_ie = 0;    bus.enable_wreg_ie = 1;
        bus.mem_to_reg_ie = 1;     bus.enable_wmem_ie = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        {m_alu, m_wd, m_dst, m_wreg, m_m2r, m_wmem} = '0;
        check_om();
        step();
        rst = 0;
        bus.enable_wreg_ie = 0; bus.mem_to_reg_ie = 0;
        bus.enable_wmem_ie = 0;

        bus.enable_wreg_iwb = 1; bus.dst_reg_addr_iwb5 = 5;
        bus.res_iwb32 = 32'h1234; bus.instr_id32 = mk(5, 6, 0);
        #1 chk("wt_rd1", bus.rd1_o32, 32'h1234);
        step();
        bus.dst_reg_addr_iwb5 = 6; bus.res_iwb32 = 32'h55;
        #1 chk("held_rd1", bus.rd1_o32, 32'h1234);
        chk("wt_rd2", bus.rd2_o32, 32'h55);
        step();
        bus.dst_reg_addr_iwb5 = 0; bus.res_iwb32 = 32'hDEAD;
        bus.instr_id32 = mk(0, 0, 0);
        step();
        bus.enable_wreg_iwb = 0;
        #1 chk("r0_rd1", bus.rd1_o32, 32'd0);

        bus.instr_id32 = mk(0, 0, 16'hFFFC); bus.pc_plus4_id32 = 32'h100;
        #1 chk("simm", bus.sign_imm_o32, 32'hFFFFFFFC);
        chk("pcb", bus.pc_branch_o32, 32'hF0);
        step();
        bus.instr_id32 = mk(0, 0, 16'h01C0);
        #1 chk("shamt7", bus.se_shamt_o32, 32'd7);
        step();

        bus.b_alu_input_ie = 1; bus.sign_imm_ie32 = 32'h55;
        bus.enable_wmem_ie = 1;
        step();
        chk("pipe_alu", bus.alu_out_om32, 32'h55);
        chk("pipe_wmem", {31'd0, bus.enable_wmem_om}, 32'd1);
        bus.instr_id32 = mk(5, 6, 0);
        bus.forward_rd1_id = 1; bus.branch_i = 1;
        #1 chk("fwd_eq", {31'd0, bus.id_eq_o}, 32'd1);
        chk("fwd_br", {31'd0, bus.branch_o}, 32'd1);
        step();
        bus.branch_i = 0;
        #1 chk("nobr", {31'd0, bus.branch_o}, 32'd0);
        step();
        bus.forward_rd1_id = 0; bus.branch_i = 1;
        #1 chk("neq", {31'd0, bus.id_eq_o}, 32'd0);
        step();
        bus.branch_i = 0; bus.enable_wmem_ie = 0;

        bus.b_alu_input_ie = 0; bus.alu_alt_ctrl_ie2 = 2;
        bus.funct_ie6 = 6'h22; bus.rd1_ie32 = 5; bus.rd2_ie32 = 7;
        #1 chk("sub", bus.ex_alu_out_o32, 32'hFFFFFFFE);
        chk("sub_z", {31'd0, bus.ex_zero_o}, 32'd0);
        step();
        bus.alu_alt_ctrl_ie2 = 3; bus.rd1_ie32 = 32'hFFFFFFFF;
        bus.rd2_ie32 = 1;
        #1 chk("slt", bus.ex_alu_out_o32, 32'd1);
        step();
        bus.apply_shift_ie = 1; bus.se_shamt_ie32 = 4;
        bus.alu_alt_ctrl_ie2 = 2; bus.funct_ie6 = 6'h00;
        #1 chk("sll", bus.ex_alu_out_o32, 32'h10);
        step();
        bus.apply_shift_ie = 0; bus.alu_alt_ctrl_ie2 = 1;
        bus.rd1_ie32 = 7; bus.rd2_ie32 = 7;
        #1 chk("zero", {31'd0, bus.ex_zero_o}, 32'd1);
        step();

        bus.forward_src_b_ie2 = 1; bus.res_iwb32 = 32'hAA;
        #1 chk("fwd_b", bus.ex_write_data_o32, 32'hAA);
        step();
        bus.forward_src_a_ie2 = 2; bus.alu_alt_ctrl_ie2 = 0;
        bus.b_alu_input_ie = 1; bus.sign_imm_ie32 = 0;
        bus.reg_dst_rtrd_ie = 1; bus.rd_ie5 = 9; bus.rt_ie5 = 3;
        #1 chk("fwd_a", bus.ex_alu_out_o32, m_alu);
        chk("rtrd", {27'd0, bus.ex_dst_reg_addr_o5}, 32'd9);
        step();

        bus.enable_wreg_ie = 1; bus.enable_wmem_ie = 1;
        bus.sign_imm_ie32 = 32'h77;
        bus.enable_wreg_iwb = 1; bus.dst_reg_addr_iwb5 = 7;
        rst = 1;
        step();
        chk("rst_alu", bus.alu_out_om32, 32'd0);
        rst = 0; bus.enable_wreg_iwb = 0;
        bus.instr_id32 = mk(5, 7, 0);
        #1 chk("rst_rf5", bus.rd1_o32, 32'd0);
        chk("rst_rf7", bus.rd2_o32, 32'd0);
        step();

        for (int n = 0; n < 300; n++) begin
            logic [5:0] fl [7];
            fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
            rst = ($urandom_range(0, 24) == 0);
            bus.instr_id32 = {6'($urandom), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 16'($urandom)};
            bus.pc_plus4_id32 = $urandom;
            bus.branch_i = 1'($urandom);
            bus.forward_rd1_id = 1'($urandom);
            bus.forward_rd2_id = 1'($urandom);
            bus.enable_wreg_iwb = 1'($urandom);
            bus.dst_reg_addr_iwb5 = 5'($urandom_range(0, 7));
            bus.res_iwb32 = $urandom;
            bus.rd1_ie32 = ($urandom_range(0, 3) == 0) ? 32'd3 : $urandom;
            bus.rd2_ie32 = ($urandom_range(0, 3) == 0) ? 32'd3 : $urandom;
            bus.sign_imm_ie32 = $urandom;
            bus.se_shamt_ie32 = 32'($urandom_range(0, 31));
            bus.rt_ie5 = 5'($urandom);
            bus.rd_ie5 = 5'($urandom);
            bus.funct_ie6 = ($urandom_range(0, 3) == 0) ?
                            6'($urandom) : fl[$urandom_range(0, 6)];
            bus.forward_src_a_ie2 = 2'($urandom);
            bus.forward_src_b_ie2 = 2'($urandom);
            bus.alu_alt_ctrl_ie2 = 2'($urandom);
            bus.reg_dst_rtrd_ie = 1'($urandom);
            bus.b_alu_input_ie = 1'($urandom);
            bus.apply_shift_ie = 1'($urandom);
            bus.enable_wreg_ie = 1'($urandom);
            bus.mem_to_reg_ie = 1'($urandom);
            bus.enable_wmem_ie = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
